// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch PC owner and PC-tagged circular instruction FIFO feeding decode
module fetch_buffer #(
  parameter int          CORE_WIDTH = 2,
  parameter int          BUF_DEPTH  = 8,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  pc_addr_o,
  input  logic [CORE_WIDTH*32-1:0]     instruction_blk_i,
  input  logic                         redirect_valid_i,
  input  logic [31:0]                  redirect_pc_i,
  input  logic                         dec_ready_i,
  output logic [CORE_WIDTH-1:0]        dec_valid_o,
  output logic [CORE_WIDTH*32-1:0]     dec_instr_o,
  output logic [CORE_WIDTH*32-1:0]     dec_pc_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH+1);
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, nvalid;
  logic [31:0]   pc_q [BUF_DEPTH];
  logic [31:0]   instr_q [BUF_DEPTH];
  logic          enq, deq;
  assign pc_addr_o   = fetch_pc_q;
  assign buf_count_o = count_q;
  assign nvalid = (count_q < CW'(CORE_WIDTH)) ? count_q : CW'(CORE_WIDTH);
  // space check deliberately ignores this cycle's dequeue
  assign enq = !redirect_valid_i && (CW'(BUF_DEPTH) - count_q >= CW'(CORE_WIDTH));
  assign deq = dec_ready_i && !redirect_valid_i;
  always_comb begin
    fetch_pc_d = redirect_valid_i ? {redirect_pc_i[31:2], 2'b00}
               : enq ? fetch_pc_q + 32'(4*CORE_WIDTH) : fetch_pc_q;
    wr_ptr_d   = redirect_valid_i ? '0 : enq ? wr_ptr_q + PW'(CORE_WIDTH) : wr_ptr_q;
    rd_ptr_d   = redirect_valid_i ? '0 : deq ? rd_ptr_q + PW'(nvalid) : rd_ptr_q;
    count_d    = redirect_valid_i ? '0
               : count_q + (enq ? CW'(CORE_WIDTH) : '0) - (deq ? nvalid : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq)
      for (int i = 0; i < CORE_WIDTH; i++) begin
        instr_q[wr_ptr_q + PW'(i)] <= instruction_blk_i[32*i +: 32];
        pc_q[wr_ptr_q + PW'(i)]    <= fetch_pc_q + 32'(4*i);
      end
  end
  for (genvar g = 0; g < CORE_WIDTH; g++) begin : g_lane
    logic [PW-1:0] idx;
    assign idx                    = rd_ptr_q + PW'(g);
    assign dec_valid_o[g]         = CW'(g) < nvalid;
    assign dec_instr_o[32*g +: 32] = dec_valid_o[g] ? instr_q[idx] : 32'h00000013;
    assign dec_pc_o[32*g +: 32]    = dec_valid_o[g] ? pc_q[idx] : 32'h0;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed table, hand sequences and random traffic against a queue model
module tb_fetch_buffer;
  logic        clk = 0, rst = 1;
  logic [31:0] pc_addr, redirect_pc = 0;
  logic [63:0] instruction_blk, dec_instr, dec_pc;
  logic        redirect_valid = 0, dec_ready = 0;
  logic [1:0]  dec_valid;
  logic [3:0]  buf_count;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  typedef struct {bit rv; logic [31:0] rpc; bit rdy; int cnt; logic [31:0] pca; logic [1:0] v; logic [31:0] i0; logic [31:0] i1;} vec_t;
  vec_t tbl [12];
  fetch_buffer dut (
    .clk(clk), .rst(rst), .pc_addr_o(pc_addr), .instruction_blk_i(instruction_blk),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc), .dec_ready_i(dec_ready),
    .dec_valid_o(dec_valid), .dec_instr_o(dec_instr), .dec_pc_o(dec_pc), .buf_count_o(buf_count)
  );
  always #5 clk = ~clk;
  // memory word at byte address a holds a>>2
  assign instruction_blk = {(pc_addr + 32'd4) >> 2, pc_addr >> 2};
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check(input string nm, input logic [31:0] pca, input int cnt, input logic [1:0] v,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0, input logic [31:0] p1);
    cmp({nm, " pc_addr"}, pc_addr, pca);
    cmp({nm, " buf_count"}, 32'(buf_count), 32'(cnt));
    cmp({nm, " dec_valid"}, 32'(dec_valid), 32'(v));
    cmp({nm, " instr0"}, dec_instr[31:0], i0);
    cmp({nm, " instr1"}, dec_instr[63:32], i1);
    cmp({nm, " pc0"}, dec_pc[31:0], p0);
    cmp({nm, " pc1"}, dec_pc[63:32], p1);
  endtask
  task automatic check_model(input string nm);
    int n;
    n = mq.size() < 2 ? mq.size() : 2;
    check(nm, mpc, mq.size(), n == 2 ? 2'b11 : n == 1 ? 2'b01 : 2'b00,
          n > 0 ? mq[0].ins : 32'h13, n > 1 ? mq[1].ins : 32'h13,
          n > 0 ? mq[0].pc : 32'h0, n > 1 ? mq[1].pc : 32'h0);
  endtask
  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy);
    int  n;
    bit  room;
    ent_t e;
    if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      n = mq.size() < 2 ? mq.size() : 2;
      room = (8 - mq.size()) >= 2;
      if (rdy) repeat (n) void'(mq.pop_front());
      if (room) begin
        for (int i = 0; i < 2; i++) begin
          e.pc = mpc + 32'(4*i);
          e.ins = e.pc >> 2;
          mq.push_back(e);
        end
        mpc = mpc + 32'd8;
      end
    end
  endtask
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc = rpc;
    dec_ready = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tbl = '{
      '{1'b0, 32'h0,  1'b0, 2, 32'h08, 2'b11, 32'd0,  32'd1},
      '{1'b0, 32'h0,  1'b0, 4, 32'h10, 2'b11, 32'd0,  32'd1},
      '{1'b0, 32'h0,  1'b0, 6, 32'h18, 2'b11, 32'd0,  32'd1},
      '{1'b0, 32'h0,  1'b0, 8, 32'h20, 2'b11, 32'd0,  32'd1},
      '{1'b0, 32'h0,  1'b0, 8, 32'h20, 2'b11, 32'd0,  32'd1},
      '{1'b0, 32'h0,  1'b1, 6, 32'h20, 2'b11, 32'd2,  32'd3},
      '{1'b0, 32'h0,  1'b1, 6, 32'h28, 2'b11, 32'd4,  32'd5},
      '{1'b0, 32'h0,  1'b1, 6, 32'h30, 2'b11, 32'd6,  32'd7},
      '{1'b0, 32'h0,  1'b1, 6, 32'h38, 2'b11, 32'd8,  32'd9},
      '{1'b0, 32'h0,  1'b1, 6, 32'h40, 2'b11, 32'd10, 32'd11},
      '{1'b1, 32'h43, 1'b1, 0, 32'h40, 2'b00, 32'h13, 32'h13},
      '{1'b0, 32'h0,  1'b1, 2, 32'h48, 2'b11, 32'd16, 32'd17}
    };
    repeat (2) @(negedge clk);
    check("in_reset", 32'h0, 0, 2'b00, 32'h13, 32'h13, 32'h0, 32'h0);
    rst = 0;
    mpc = 32'h0;
    #1 check("after_reset", 32'h0, 0, 2'b00, 32'h13, 32'h13, 32'h0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].rv, tbl[k].rpc, tbl[k].rdy);
      check($sformatf("vec%0d", k), tbl[k].pca, tbl[k].cnt, tbl[k].v, tbl[k].i0, tbl[k].i1,
            tbl[k].v[0] ? tbl[k].i0 << 2 : 32'h0, tbl[k].v[1] ? tbl[k].i1 << 2 : 32'h0);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    check_model("fill_to_6");
    #2 rst = 1;
    #1 check("rst_async", 32'h0, 0, 2'b00, 32'h13, 32'h13, 32'h0, 32'h0);
    mq.delete();
    mpc = 32'h0;
    @(negedge clk);
    rst = 0;
    step(0, 0, 0);
    check("restart", 32'h8, 2, 2'b11, 32'd0, 32'd1, 32'h0, 32'h4);
    step(1, 32'hFFFF_FFFA, 1);
    check_model("redir_top");
    step(0, 0, 1);
    check_model("pc_wrap0");
    step(0, 0, 1);
    check_model("pc_wrap1");
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 24) == 0, $urandom,
           k < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0);
      check_model($sformatf("rand%0d", k));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
